// File: rtl/ccff_loader_if.sv
// ccff_loader_if: host stream, readback and chain pins of the configuration-chain loader
interface ccff_loader_if #(parameter int CNT_W = 11);
  logic             start;
  logic [31:0]      s_data;
  logic             s_valid;
  logic             s_ready;
  logic             ccff_head;
  logic             ccff_shift_en;
  logic             ccff_tail;
  logic [31:0]      rb_data;
  logic             rb_valid;
  logic             rb_ready;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_count;
  modport master (
    output start, s_data, s_valid, ccff_tail, rb_ready,
    input  s_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done, bit_count
  );
  modport slave (
    input  start, s_data, s_valid, ccff_tail, rb_ready,
    output s_ready, ccff_head, ccff_shift_en, rb_data, rb_valid, busy, done, bit_count
  );
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: shifts CHAIN_LEN bitstream bits into the config chain head and
// packs the bits falling out of the tail into 32-bit readback words.
module ccff_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input logic         prog_clk,
  input logic         prog_reset_n,
  ccff_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
  localparam int               NW   = (CHAIN_LEN + 31) / 32;
  localparam logic [CNT_W-1:0] CL   = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] NW_C = CNT_W'(NW);
  localparam logic [5:0]       LAST = (CHAIN_LEN % 32 == 0) ? 6'd32 : 6'(CHAIN_LEN % 32);
  state_t           state_q, state_d;
  logic [31:0]      word_q, word_d, acc_q, acc_d, rb_q, rb_d, acc_b;
  logic [5:0]       left_q, left_d, acc_n_q, acc_n_d, n_b;
  logic [CNT_W-1:0] bit_count_q, bit_count_d, words_q, words_d;
  logic             rbv_q, rbv_d;
  logic             load, clr, acc_full, shift, ready, take, xfer;
  always_comb begin
    load        = state_q == LOAD;
    clr         = bus.start && (state_q == IDLE || state_q == DONE);
    acc_full    = acc_n_q == 6'd32 || (bit_count_q == CL && acc_n_q != 6'd0);
    shift       = load && left_q != 6'd0 && bit_count_q < CL && !(acc_full && rbv_q);
    ready       = load && words_q < NW_C && (left_q == 6'd0 || (shift && left_q == 6'd1));
    take        = ready && bus.s_valid;
    xfer        = acc_full && !rbv_q;
    // A full accumulator moves to the readback register in the same cycle a new tail bit lands
    acc_b       = xfer ? '0 : acc_q;
    n_b         = xfer ? '0 : acc_n_q;
    word_d      = clr ? '0 : take ? bus.s_data : shift ? {word_q[30:0], 1'b0} : word_q;
    left_d      = clr ? '0 : take ? ((words_q == NW_C - 1'b1) ? LAST : 6'd32) : left_q - 6'(shift);
    acc_d       = clr ? '0 : shift ? (acc_b | ({31'b0, bus.ccff_tail} << (5'd31 - n_b[4:0]))) : acc_b;
    acc_n_d     = clr ? '0 : n_b + 6'(shift);
    words_d     = clr ? '0 : words_q + CNT_W'(take);
    bit_count_d = clr ? '0 : bit_count_q + CNT_W'(shift);
    rb_d        = xfer ? acc_q : rb_q;
    rbv_d       = xfer || (rbv_q && !bus.rb_ready);
    state_d     = clr ? LOAD :
                  (load && bit_count_q == CL) ? FLUSH :
                  (state_q == FLUSH && acc_n_q == 6'd0 && (!rbv_q || bus.rb_ready)) ? DONE :
                  state_q;
  end
  always_ff @(posedge prog_clk or negedge prog_reset_n)
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      left_q      <= '0;
      acc_q       <= '0;
      acc_n_q     <= '0;
      words_q     <= '0;
      bit_count_q <= '0;
      rb_q        <= '0;
      rbv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      left_q      <= left_d;
      acc_q       <= acc_d;
      acc_n_q     <= acc_n_d;
      words_q     <= words_d;
      bit_count_q <= bit_count_d;
      rb_q        <= rb_d;
      rbv_q       <= rbv_d;
    end
  assign bus.s_ready       = ready;
  assign bus.ccff_head     = word_q[31];
  assign bus.ccff_shift_en = shift;
  assign bus.rb_data       = rb_q;
  assign bus.rb_valid      = rbv_q;
  assign bus.busy          = load || state_q == FLUSH;
  assign bus.done          = state_q == DONE;
  assign bus.bit_count     = bit_count_q;
endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader: randomized loads of a 70-bit chain; expected readback words
// are queued at start and popped by an independent readback monitor.
module tb_ccff_loader;
  localparam int LEN = 70;
  logic prog_clk = 1'b0;
  logic prog_reset_n;
  ccff_loader_if #(.CNT_W(7)) bus();
  ccff_loader #(.CHAIN_LEN(LEN), .CNT_W(7)) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .bus(bus)
  );
  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: shifts in at the head, oldest bit falls out of the tail
  logic [LEN-1:0] chain, pre_img, img1;
  logic           pre;
  always @(posedge prog_clk)
    if (pre) chain <= pre_img;
    else if (bus.ccff_shift_en) chain <= {chain[LEN-2:0], bus.ccff_head};
  assign bus.ccff_tail = chain[LEN-1];

  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, t_acc = 0, nxt = 0, vmode = 0, rmode = 0;
  logic        extra;
  logic [31:0] w[3];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Readback is the prior chain image, first-out bit first, packed MSB-first and zero-padded
  task automatic push_rb(input logic [LEN-1:0] c);
    logic [95:0] p;
    p = {c, 26'b0};
    for (int k = 0; k < 3; k++) exp_q.push_back(p[95-32*k -: 32]);
  endtask

  task automatic step();
    logic hs;
    hs = bus.s_valid && bus.s_ready;
    if (nxt >= 3 && bus.s_ready) extra = 1'b1;
    @(posedge prog_clk); #1;
    cyc++;
    if (hs) begin
      if (nxt == 0) t_acc = cyc;
      nxt++;
    end
    bus.s_valid = nxt < 3 && (vmode == 0 || (vmode == 1 && cyc % 3 == 0) ||
                              (vmode == 2 && $urandom_range(0, 1) == 1));
    bus.s_data  = nxt < 3 ? w[nxt] : $urandom;
    if (rmode != 1) bus.rb_ready = rmode == 0 || $urandom_range(0, 1) == 1;
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_head"},     bus.ccff_head, 0);
    chk({tag, "_shift_en"}, bus.ccff_shift_en, 0);
    chk({tag, "_s_ready"},  bus.s_ready, 0);
    chk({tag, "_rb_valid"}, bus.rb_valid, 0);
    chk({tag, "_rb_data"},  bus.rb_data, 0);
    chk({tag, "_busy"},     bus.busy, 0);
    chk({tag, "_done"},     bus.done, 0);
    chk({tag, "_bit_count"}, bus.bit_count, 0);
  endtask

  task automatic begin_load(input bit reuse);
    if (!reuse) foreach (w[i]) w[i] = $urandom;
    nxt   = 0;
    extra = 1'b0;
    push_rb(chain);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_s_ready", bus.s_ready, 1);
  endtask

  task automatic finish_load(input int exp_lat);
    logic [95:0] cat;
    for (int i = 0; i < 1000 && !bus.done; i++) step();
    chk("done", bus.done, 1);
    if (exp_lat > 0) chk("latency", cyc - t_acc, exp_lat);
    cat = {w[0], w[1], w[2]};
    chk("image", chain, cat[95:26]);
    chk("bit_count", bus.bit_count, LEN);
    chk("rb_drained", exp_q.size(), 0);
    chk("words_taken", nxt, 3);
    chk("no_4th_ready", extra, 0);
    chk("busy_off", bus.busy, 0);
  endtask

  logic [31:0] held;
  logic        held_v = 1'b0;
  initial forever begin
    @(negedge prog_clk);
    if (bus.rb_valid && held_v) chk("rb_stable", bus.rb_data, held);
    if (bus.rb_valid && bus.rb_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rb_extra: got %0h expected no word", bus.rb_data);
      end else chk("rb_data", bus.rb_data, exp_q.pop_front());
    end
    held_v = bus.rb_valid && !bus.rb_ready;
    held   = bus.rb_data;
  end

  initial begin
    bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = '0; bus.rb_ready = 1'b0;
    prog_reset_n = 1'b0;
    pre_img = {6'h2A, 32'hDEADBEEF, 32'h01234567};
    pre = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1 pre = 1'b0;
    rst_checks("por");
    prog_reset_n = 1'b1;
    // Back-to-back words, readback always accepted
    vmode = 0; rmode = 0;
    begin_load(0);
    finish_load(LEN + 2);
    img1 = chain;
    // Same words with sparse s_valid must leave the same image
    vmode = 1;
    begin_load(1);
    finish_load(0);
    chk("sparse_same_image", chain, img1);
    // Readback held off: shifting stalls once the accumulator fills behind a pending word
    vmode = 0; rmode = 1; bus.rb_ready = 1'b0;
    begin_load(0);
    for (int i = 0; i < 300 && bus.bit_count != 7'd64; i++) step();
    repeat (3) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    chk("stall_shift_en", bus.ccff_shift_en, 0);
    chk("stall_bit_count", bus.bit_count, 64);
    chk("stall_busy", bus.busy, 1);
    chk("stall_rb_valid", bus.rb_valid, 1);
    bus.rb_ready = 1'b1;
    finish_load(0);
    // Reset mid-load, then a fresh load reads back the partial image
    rmode = 0;
    begin_load(0);
    for (int i = 0; i < 300 && bus.bit_count != 7'd20; i++) step();
    chk("pre_reset_count", bus.bit_count, 20);
    #2 prog_reset_n = 1'b0;
    #1 rst_checks("midrst");
    exp_q.delete();
    @(posedge prog_clk);
    #1 prog_reset_n = 1'b1;
    vmode = 2; rmode = 2;
    for (int n = 0; n < 4; n++) begin
      begin_load(0);
      finish_load(0);
    end
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
